// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: slot counter, digit select, hex decode, guarded anodes.
// Optional blink gating is compiled in with BLINK_EN; without it the blink port is ignored.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] digit_mask,
  input  logic       blink,
  input  logic [3:0] y_in,
  output logic [1:0] ss,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int            TW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] GUARD     = TW'(GUARD_CYCLES);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    ss_q, ss_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          blink_on;

`ifdef BLINK_EN
  localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Free-running: blink cadence is independent of enable.
  always_comb begin
    bcnt_d  = bcnt_q + BW'(1);
    phase_d = phase_q;
    if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_on = ~blink | phase_q;
`else
  // Port retained for pin compatibility; the gate is permanently open.
  assign blink_on = blink | 1'b1;
`endif

  always_comb begin
    tick_d = tick_q;
    ss_d   = ss_q;
    if (enable) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        ss_d   = ss_q + 2'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
  end

  always_comb begin
    case (y_in)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  // Guard window keeps anodes dark while seg settles on the new digit's code.
  always_comb begin
    an_d = 4'b1111;
    if (enable && (tick_q >= GUARD) && !digit_mask[ss_q] && blink_on) begin
      an_d = ~(4'b0001 << ss_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      ss_q   <= 2'd0;
      seg_q  <= 7'b1111111;
      an_q   <= 4'b1111;
    end else begin
      tick_q <= tick_d;
      ss_q   <= ss_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign ss  = ss_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver at REFRESH_DIV=8, GUARD_CYCLES=2, BLINK_DIV=16.
// Per-cycle expected {ss,an,seg} is queued by a reference model and popped after each edge.
module tb_seven_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset, enable, blink;
  logic [3:0] digit_mask, y_in, y_val;
  logic [1:0] ss;
  logic [6:0] seg;
  logic [3:0] an;
  logic       mux_mode;

  logic [6:0] seg_tbl [16];
  logic [3:0] digits  [4];

`ifdef BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  int         m_tick, m_bcnt;
  logic [1:0] m_ss;
  logic       m_phase;
  logic [12:0] sb [$];
  logic [12:0] exp_v;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign y_in = mux_mode ? digits[ss] : y_val;

  seven_seg_scan_driver #(
    .REFRESH_DIV (8),
    .GUARD_CYCLES(2),
    .BLINK_DIV   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .digit_mask(digit_mask),
    .blink     (blink),
    .y_in      (y_in),
    .ss        (ss),
    .seg       (seg),
    .an        (an)
  );

  // Reference model: computes what the outputs must be after the coming edge.
  task automatic drive_cycle();
    logic [3:0] y_now, e_an;
    logic [6:0] e_seg;
    logic [1:0] e_ss;
    y_now = mux_mode ? digits[m_ss] : y_val;
    if (reset) begin
      e_ss = 2'd0; e_an = 4'hF; e_seg = 7'h7F;
      m_tick = 0; m_ss = 2'd0; m_phase = 1'b1; m_bcnt = 0;
    end else begin
      e_seg = seg_tbl[y_now];
      if (!enable || m_tick < 2 || digit_mask[m_ss] || (BLINK_BUILT && blink && !m_phase))
        e_an = 4'hF;
      else
        e_an = ~(4'b0001 << m_ss);
      if (enable) begin
        if (m_tick == 7) begin m_tick = 0; m_ss = m_ss + 2'd1; end
        else m_tick++;
      end
      e_ss = m_ss;
      if (m_bcnt == 15) begin m_bcnt = 0; m_phase = !m_phase; end
      else m_bcnt++;
    end
    sb.push_back({e_ss, e_an, e_seg});
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; blink = 1'b0; digit_mask = 4'h0;
    mux_mode = 1'b0; y_val = 4'h8;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v || {ss, an, seg} !== {2'd0, 4'hF, 7'h7F}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got ss=%0d an=%b seg=%b, expected ss=0 an=1111 seg=1111111",
                 i, ss, an, seg);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    int cnt_on [4];
    int cnt_off;
    logic [1:0] prev_ss;
    bit wrapped;
    cnt_off = 0; wrapped = 1'b0; prev_ss = ss;
    for (int k = 0; k < 4; k++) cnt_on[k] = 0;
    enable = 1'b1; digit_mask = 4'h0; mux_mode = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v) begin
        n_fail++;
        $display("FAIL scan[%0d]: got ss=%0d an=%b seg=%b, expected ss=%0d an=%b seg=%b",
                 i, ss, an, seg, exp_v[12:11], exp_v[10:7], exp_v[6:0]);
      end
      if (prev_ss == 2'd3 && ss == 2'd0) wrapped = 1'b1;
      prev_ss = ss;
      if (an == 4'hF) cnt_off++;
      for (int k = 0; k < 4; k++) begin
        if (an == ~(4'b0001 << k)) begin
          cnt_on[k]++;
          n_checks++;
          if (seg !== seg_tbl[digits[k]]) begin
            n_fail++;
            $display("FAIL scan_seg_digit%0d: got seg=%b, expected %b", k, seg, seg_tbl[digits[k]]);
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (cnt_on[k] != 12) begin
        n_fail++;
        $display("FAIL scan_on_cycles_digit%0d: got %0d, expected 12", k, cnt_on[k]);
      end
    end
    n_checks++;
    if (cnt_off != 16) begin
      n_fail++;
      $display("FAIL scan_guard_cycles: got %0d, expected 16", cnt_off);
    end
    n_checks++;
    if (!wrapped) begin
      n_fail++;
      $display("FAIL scan_ss_wrap: got no 3->0 transition, expected one");
    end
  endtask

  task automatic test_decode();
    enable = 1'b0; mux_mode = 1'b0;
    y_val = 4'hA;
    drive_cycle();
    exp_v = sb.pop_front();
    n_checks++;
    if (seg !== 7'b0001000 || {ss, an, seg} !== exp_v) begin
      n_fail++;
      $display("FAIL decode_hold_A: got ss=%0d an=%b seg=%b, expected seg=0001000 an=1111",
               ss, an, seg);
    end
    for (int v = 0; v < 16; v++) begin
      y_val = 4'(v);
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v) begin
        n_fail++;
        $display("FAIL decode_%h: got ss=%0d an=%b seg=%b, expected ss=%0d an=%b seg=%b",
                 v[3:0], ss, an, seg, exp_v[12:11], exp_v[10:7], exp_v[6:0]);
      end
    end
  endtask

  task automatic test_mask();
    int cnt_ss2, cnt_an2;
    cnt_ss2 = 0; cnt_an2 = 0;
    enable = 1'b1; digit_mask = 4'b0100; mux_mode = 1'b1;
    blink = 1'b0;
    for (int i = 0; i < 64; i++) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v) begin
        n_fail++;
        $display("FAIL mask[%0d]: got ss=%0d an=%b seg=%b, expected ss=%0d an=%b seg=%b",
                 i, ss, an, seg, exp_v[12:11], exp_v[10:7], exp_v[6:0]);
      end
      if (ss == 2'd2) cnt_ss2++;
      if (an == 4'b1011) cnt_an2++;
    end
    n_checks++;
    if (cnt_an2 != 0) begin
      n_fail++;
      $display("FAIL mask_an_1011_seen: got %0d cycles, expected 0", cnt_an2);
    end
    n_checks++;
    if (cnt_ss2 != 16) begin
      n_fail++;
      $display("FAIL mask_ss2_slots: got %0d cycles, expected 16", cnt_ss2);
    end
    digit_mask = 4'h0;
  endtask

  task automatic test_enable_freeze();
    int budget;
    enable = 1'b1; mux_mode = 1'b1; budget = 0;
    while (!(m_tick == 4 && m_ss == 2'd1) && budget < 40) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v) begin
        n_fail++;
        $display("FAIL freeze_approach: got ss=%0d an=%b, expected ss=%0d an=%b",
                 ss, an, exp_v[12:11], exp_v[10:7]);
      end
      budget++;
    end
    n_checks++;
    if (budget >= 40) begin
      n_fail++;
      $display("FAIL freeze_reach_slot: got no tick=4 on ss=1 within %0d cycles, expected it", budget);
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v || ss !== 2'd1 || an !== 4'hF) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d]: got ss=%0d an=%b, expected ss=1 an=1111", i, ss, an);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v || (i < 4 && an !== 4'b1101)) begin
        n_fail++;
        $display("FAIL freeze_resume[%0d]: got ss=%0d an=%b seg=%b, expected ss=%0d an=%b seg=%b",
                 i, ss, an, seg, exp_v[12:11], exp_v[10:7], exp_v[6:0]);
      end
    end
  endtask

  task automatic test_reset_midslot();
    enable = 1'b1; mux_mode = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_cycle();
      void'(sb.pop_front());
    end
    reset = 1'b1;
    drive_cycle();
    exp_v = sb.pop_front();
    n_checks++;
    if ({ss, an, seg} !== exp_v) begin
      n_fail++;
      $display("FAIL reset_midslot: got ss=%0d an=%b seg=%b, expected ss=0 an=1111 seg=1111111",
               ss, an, seg);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v) begin
        n_fail++;
        $display("FAIL reset_restart[%0d]: got ss=%0d an=%b, expected ss=%0d an=%b",
                 i, ss, an, exp_v[12:11], exp_v[10:7]);
      end
    end
  endtask

  task automatic test_blink();
    int budget;
    enable = 1'b1; mux_mode = 1'b1; digit_mask = 4'h0; blink = 1'b1;
    for (int i = 0; i < 96; i++) begin
      if (i == 64) blink = 1'b0;
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v) begin
        n_fail++;
        $display("FAIL blink[%0d] blink=%0d: got ss=%0d an=%b, expected ss=%0d an=%b",
                 i, blink, ss, an, exp_v[12:11], exp_v[10:7]);
      end
    end
    blink = 1'b1; budget = 0;
    while (m_phase && budget < 40) begin
      drive_cycle();
      void'(sb.pop_front());
      budget++;
    end
    repeat (3) begin
      drive_cycle();
      void'(sb.pop_front());
    end
    reset = 1'b1;
    drive_cycle();
    void'(sb.pop_front());
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      exp_v = sb.pop_front();
      n_checks++;
      if ({ss, an, seg} !== exp_v) begin
        n_fail++;
        $display("FAIL blink_after_reset[%0d]: got ss=%0d an=%b, expected ss=%0d an=%b",
                 i, ss, an, exp_v[12:11], exp_v[10:7]);
      end
    end
    blink = 1'b0;
  endtask

  initial begin
    seg_tbl[0]  = 7'b1000000; seg_tbl[1]  = 7'b1111001; seg_tbl[2]  = 7'b0100100;
    seg_tbl[3]  = 7'b0110000; seg_tbl[4]  = 7'b0011001; seg_tbl[5]  = 7'b0010010;
    seg_tbl[6]  = 7'b0000010; seg_tbl[7]  = 7'b1111000; seg_tbl[8]  = 7'b0000000;
    seg_tbl[9]  = 7'b0010000; seg_tbl[10] = 7'b0001000; seg_tbl[11] = 7'b0000011;
    seg_tbl[12] = 7'b1000110; seg_tbl[13] = 7'b0100001; seg_tbl[14] = 7'b0000110;
    seg_tbl[15] = 7'b0001110;
    digits[0] = 4'h1; digits[1] = 4'h2; digits[2] = 4'h3; digits[3] = 4'h4;
    m_tick = 0; m_ss = 2'd0; m_phase = 1'b1; m_bcnt = 0;
    reset = 1'b1; enable = 1'b0; blink = 1'b0; digit_mask = 4'h0;
    mux_mode = 1'b0; y_val = 4'h0;
    @(posedge clk); #1;

    test_reset();
    test_scan();
    test_decode();
    test_mask();
    test_enable_freeze();
    test_reset_midslot();
    test_blink();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
